add_pipe: RTL and testbench



---
 rtl/add_pipe_pkg.sv | 16 +
 rtl/add_pipe_slice.sv | 102 ++++++++++
 rtl/add_pipe.sv | 94 +++++++++
 tb/tb_add_pipe.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/add_pipe_pkg.sv
// ============================================================================
// add_pipe_pkg : operation-mode encodings shared by the add_pipe datapath
// Revision     : 1.0 - initial release
// ============================================================================
`default_nettype none

package add_pipe_pkg;

  localparam logic OP_ADD        = 1'b0;
  localparam logic OP_SUB        = 1'b1;
  localparam logic MODE_UNSIGNED = 1'b0;
  localparam logic MODE_SIGNED   = 1'b1;

endpackage : add_pipe_pkg

`default_nettype wire

// File: rtl/add_pipe_slice.sv
// ============================================================================
// add_slice : one registered CHUNK-bit carry-propagating adder stage
// Revision  : 1.0 - initial release
// ============================================================================
`default_nettype none

module add_slice
  import add_pipe_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4,
  parameter int IDX   = 0,
  parameter bit LAST  = 1'b0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             valid_i,
  input  logic             sub_i,
  input  logic             signed_i,
  input  logic             carry_i,
  input  logic [WIDTH:0]   a_i,
  input  logic [WIDTH:0]   b_i,
  input  logic [WIDTH:0]   y_i,
  output logic             valid_o,
  output logic             sub_o,
  output logic             signed_o,
  output logic             carry_o,
  output logic             ovf_o,
  output logic [WIDTH:0]   a_o,
  output logic [WIDTH:0]   b_o,
  output logic [WIDTH:0]   y_o
);

  localparam int LO = IDX * CHUNK;

  logic [CHUNK:0] w_sum;
  logic [WIDTH:0] y_d;
  logic           ovf_d;

  logic           valid_q;
  logic           sub_q;
  logic           signed_q;
  logic           carry_q;
  logic           ovf_q;
  logic [WIDTH:0] a_q;
  logic [WIDTH:0] b_q;
  logic [WIDTH:0] y_q;

  assign w_sum = {1'b0, a_i[LO +: CHUNK]} + {1'b0, b_i[LO +: CHUNK]}
               + {{CHUNK{1'b0}}, carry_i};

  // The last stage also folds the extension bit in, using its own carry-out.
  always_comb begin
    y_d              = y_i;
    y_d[LO +: CHUNK] = w_sum[CHUNK-1:0];
    if (LAST) begin
      y_d[WIDTH] = a_i[WIDTH] ^ b_i[WIDTH] ^ w_sum[CHUNK];
    end
  end

  always_comb begin
    ovf_d = y_d[WIDTH];
    if (signed_i == MODE_SIGNED) begin
      ovf_d = y_d[WIDTH] ^ y_d[WIDTH-1];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q  <= 1'b0;
      sub_q    <= 1'b0;
      signed_q <= 1'b0;
      carry_q  <= 1'b0;
      ovf_q    <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      y_q      <= '0;
    end else if (en_i) begin
      valid_q  <= valid_i;
      sub_q    <= sub_i;
      signed_q <= signed_i;
      carry_q  <= w_sum[CHUNK];
      ovf_q    <= ovf_d;
      a_q      <= a_i;
      b_q      <= b_i;
      y_q      <= y_d;
    end
  end

  assign valid_o  = valid_q;
  assign sub_o    = sub_q;
  assign signed_o = signed_q;
  assign carry_o  = carry_q;
  assign ovf_o    = ovf_q;
  assign a_o      = a_q;
  assign b_o      = b_q;
  assign y_o      = y_q;

endmodule : add_slice

`default_nettype wire

// File: rtl/add_pipe.sv
// ============================================================================
// add_pipe : pipelined signed/unsigned add/sub with valid/ready handshakes
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module add_pipe
  import add_pipe_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             in_clk,
  input  logic             in_rst,
  input  logic             in_valid,
  output logic             out_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_sub,
  input  logic             in_signed,
  output logic             out_valid,
  input  logic             in_ready,
  output logic [WIDTH:0]   out_y,
  output logic             out_ovf
);

  localparam int STAGES = WIDTH / CHUNK;

  // Index k is the input of stage k; index k+1 is its registered output.
  logic [STAGES:0] w_valid;
  logic [STAGES:0] w_sub;
  logic [STAGES:0] w_sgn;
  logic [STAGES:0] w_carry;
  logic [STAGES:0] w_ovf;
  logic [WIDTH:0]  w_a [0:STAGES];
  logic [WIDTH:0]  w_b [0:STAGES];
  logic [WIDTH:0]  w_y [0:STAGES];
  logic [WIDTH:0]  w_bx;
  logic            w_advance;
  logic            w_unused;

  assign out_ready = !out_valid || in_ready;
  assign w_advance = out_ready;

  // Subtraction is folded in up front: invert B here, carry-in of 1 below.
  assign w_bx       = {(in_signed == MODE_SIGNED) & in_b[WIDTH-1], in_b};
  assign w_a[0]     = {(in_signed == MODE_SIGNED) & in_a[WIDTH-1], in_a};
  assign w_b[0]     = (in_sub == OP_SUB) ? ~w_bx : w_bx;
  assign w_y[0]     = '0;
  assign w_valid[0] = in_valid;
  assign w_sub[0]   = in_sub;
  assign w_sgn[0]   = in_signed;
  assign w_carry[0] = (in_sub == OP_SUB);
  assign w_ovf[0]   = 1'b0;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    add_slice #(
      .WIDTH (WIDTH),
      .CHUNK (CHUNK),
      .IDX   (k),
      .LAST  (k == STAGES - 1)
    ) u_slice (
      .clk_i    (in_clk),
      .rst_i    (in_rst),
      .en_i     (w_advance),
      .valid_i  (w_valid[k]),
      .sub_i    (w_sub[k]),
      .signed_i (w_sgn[k]),
      .carry_i  (w_carry[k]),
      .a_i      (w_a[k]),
      .b_i      (w_b[k]),
      .y_i      (w_y[k]),
      .valid_o  (w_valid[k+1]),
      .sub_o    (w_sub[k+1]),
      .signed_o (w_sgn[k+1]),
      .carry_o  (w_carry[k+1]),
      .ovf_o    (w_ovf[k+1]),
      .a_o      (w_a[k+1]),
      .b_o      (w_b[k+1]),
      .y_o      (w_y[k+1])
    );
  end

  assign out_valid = w_valid[STAGES];
  assign out_y     = w_y[STAGES];
  assign out_ovf   = w_ovf[STAGES];

  // Fully resolved ops no longer need their operands or intermediate flags.
  assign w_unused = ^{w_ovf[STAGES-1:0], w_sub[STAGES], w_sgn[STAGES],
                      w_carry[STAGES], w_a[STAGES], w_b[STAGES]};

endmodule : add_pipe

`default_nettype wire

// File: tb/tb_add_pipe.sv
// ============================================================================
// tb_add_pipe : vector table, backpressure, mid-stream reset and random scoreboard
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_add_pipe;

  localparam int WIDTH  = 16;
  localparam int CHUNK  = 4;
  localparam int STAGES = WIDTH / CHUNK;

  logic              in_clk;
  logic              in_rst;
  logic              in_valid;
  logic              out_ready;
  logic [WIDTH-1:0]  in_a;
  logic [WIDTH-1:0]  in_b;
  logic              in_sub;
  logic              in_signed;
  logic              out_valid;
  logic              in_ready;
  logic [WIDTH:0]    out_y;
  logic              out_ovf;

  add_pipe #(.WIDTH(WIDTH), .CHUNK(CHUNK)) u_dut (
    .in_clk    (in_clk),
    .in_rst    (in_rst),
    .in_valid  (in_valid),
    .out_ready (out_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_sub    (in_sub),
    .in_signed (in_signed),
    .out_valid (out_valid),
    .in_ready  (in_ready),
    .out_y     (out_y),
    .out_ovf   (out_ovf)
  );

  initial in_clk = 1'b0;
  always #5 in_clk = ~in_clk;

  typedef struct {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sub;
    logic             sgn;
    logic [WIDTH:0]   y;
    logic             ovf;
  } vec_t;

  vec_t             vecs [12];
  logic [WIDTH+1:0] q [$];
  int               errors;
  int               checks;
  int               popped;
  logic             acc_last;
  logic             hold_pend;
  logic [WIDTH:0]   held_y;
  logic             held_ovf;

  // Reference: extend, add or subtract, wrap to WIDTH+1 bits; {ovf, y}.
  function automatic logic [WIDTH+1:0] model(logic [WIDTH-1:0] a, logic [WIDTH-1:0] b,
                                             logic sub, logic sgn);
    logic [WIDTH:0] ea;
    logic [WIDTH:0] eb;
    logic [WIDTH:0] y;
    logic           ovf;
    ea  = sgn ? {a[WIDTH-1], a} : {1'b0, a};
    eb  = sgn ? {b[WIDTH-1], b} : {1'b0, b};
    y   = sub ? (ea - eb) : (ea + eb);
    ovf = sgn ? (y[WIDTH] ^ y[WIDTH-1]) : y[WIDTH];
    return {ovf, y};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clock: observe handshakes at the falling edge, then step past the rising edge.
  task automatic tick();
    logic [WIDTH+1:0] e;
    @(negedge in_clk);
    acc_last = 1'b0;
    if (hold_pend) begin
      chk("hold_y", 32'(out_y), 32'(held_y));
      chk("hold_ovf", 32'(out_ovf), 32'(held_ovf));
    end
    hold_pend = out_valid && !in_ready && !in_rst;
    held_y    = out_y;
    held_ovf  = out_ovf;
    if (in_rst) begin
      q.delete();
    end else begin
      if (in_valid && out_ready) begin
        q.push_back(model(in_a, in_b, in_sub, in_signed));
        acc_last = 1'b1;
      end
      if (out_valid && in_ready) begin
        popped++;
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_unexpected: got y=%h with nothing outstanding", out_y);
        end else begin
          e = q.pop_front();
          chk("sb_y", 32'(out_y), 32'(e[WIDTH:0]));
          chk("sb_ovf", 32'(out_ovf), 32'(e[WIDTH+1]));
        end
      end
    end
    @(posedge in_clk);
    #1;
  endtask

  initial begin
    int lat;
    int sent;
    int stall_left;
    int seen;
    int base;
    logic stalled;
    vec_t ops [6];

    errors    = 0;
    checks    = 0;
    popped    = 0;
    acc_last  = 1'b0;
    hold_pend = 1'b0;
    held_y    = '0;
    held_ovf  = 1'b0;
    in_rst    = 1'b1;
    in_valid  = 1'b0;
    in_ready  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_sub    = 1'b0;
    in_signed = 1'b0;

    vecs[0]  = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 17'h10000, 1'b1};
    vecs[1]  = '{16'h0003, 16'h0005, 1'b1, 1'b0, 17'h1FFFE, 1'b1};
    vecs[2]  = '{16'h0005, 16'h0003, 1'b1, 1'b0, 17'h00002, 1'b0};
    vecs[3]  = '{16'h8000, 16'h0001, 1'b1, 1'b1, 17'h17FFF, 1'b1};
    vecs[4]  = '{16'hFFFF, 16'h0001, 1'b0, 1'b1, 17'h00000, 1'b0};
    vecs[5]  = '{16'h7FFF, 16'h0001, 1'b0, 1'b1, 17'h08000, 1'b1};
    vecs[6]  = '{16'h1234, 16'h4321, 1'b0, 1'b0, 17'h05555, 1'b0};
    vecs[7]  = '{16'h0000, 16'h0000, 1'b1, 1'b0, 17'h00000, 1'b0};
    vecs[8]  = '{16'h8000, 16'h8000, 1'b0, 1'b1, 17'h10000, 1'b1};
    vecs[9]  = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b1, 17'h00000, 1'b0};
    vecs[10] = '{16'hFFFF, 16'h0000, 1'b1, 1'b0, 17'h0FFFF, 1'b0};
    vecs[11] = '{16'h0001, 16'h8000, 1'b1, 1'b1, 17'h08001, 1'b1};

    tick();
    tick();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_ready", 32'(out_ready), 32'd1);
    chk("rst_out_y", 32'(out_y), 32'd0);
    chk("rst_out_ovf", 32'(out_ovf), 32'd0);
    in_rst   = 1'b0;
    in_ready = 1'b1;

    // Isolated ops: latency and table-driven results.
    for (int i = 0; i < 12; i++) begin
      in_a      = vecs[i].a;
      in_b      = vecs[i].b;
      in_sub    = vecs[i].sub;
      in_signed = vecs[i].sgn;
      in_valid  = 1'b1;
      tick();
      chk("vec_accept", 32'(acc_last), 32'd1);
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 20) begin
        tick();
        lat++;
      end
      chk("vec_latency", 32'(lat), 32'(STAGES));
      chk("vec_y", 32'(out_y), 32'(vecs[i].y));
      chk("vec_ovf", 32'(out_ovf), 32'(vecs[i].ovf));
      tick();
    end

    // Back-to-back mixed modes with a 3-cycle downstream stall.
    for (int i = 0; i < 6; i++) begin
      ops[i].a   = 16'($urandom);
      ops[i].b   = 16'($urandom);
      ops[i].sub = i[0];
      ops[i].sgn = i[1];
    end
    base       = popped;
    sent       = 0;
    stall_left = 0;
    stalled    = 1'b0;
    for (int t = 0; t < 60 && (sent < 6 || popped - base < 6); t++) begin
      if (!stalled && out_valid) begin
        stall_left = 3;
        stalled    = 1'b1;
      end
      in_ready = (stall_left == 0);
      in_valid = (sent < 6);
      if (sent < 6) begin
        in_a      = ops[sent].a;
        in_b      = ops[sent].b;
        in_sub    = ops[sent].sub;
        in_signed = ops[sent].sgn;
      end
      #1;
      if (stall_left > 0) begin
        chk("stall_out_ready", 32'(out_ready), 32'd0);
        stall_left--;
      end
      tick();
      if (acc_last) sent++;
    end
    in_valid = 1'b0;
    in_ready = 1'b1;
    chk("bp_sent", 32'(sent), 32'd6);
    chk("bp_popped", 32'(popped - base), 32'd6);
    chk("bp_queue_empty", 32'(q.size()), 32'd0);

    // Reset with three ops in flight: none may surface afterwards.
    for (int i = 0; i < 3; i++) begin
      in_a      = 16'($urandom);
      in_b      = 16'($urandom);
      in_sub    = 1'($urandom);
      in_signed = 1'($urandom);
      in_valid  = 1'b1;
      tick();
    end
    in_valid = 1'b1;
    in_ready = 1'b0;
    in_rst   = 1'b1;
    tick();
    in_rst   = 1'b0;
    in_valid = 1'b0;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_out_ready", 32'(out_ready), 32'd1);
    in_ready = 1'b1;
    seen = 0;
    for (int t = 0; t < 10; t++) begin
      tick();
      if (out_valid) seen++;
    end
    chk("midrst_none_emerge", 32'(seen), 32'd0);

    // Random traffic with random handshakes; data held until accepted.
    base      = popped;
    sent      = 0;
    in_a      = 16'($urandom);
    in_b      = 16'($urandom);
    in_sub    = 1'($urandom);
    in_signed = 1'($urandom);
    for (int t = 0; t < 8000 && sent < 1000; t++) begin
      in_valid = ($urandom_range(0, 9) < 7);
      in_ready = ($urandom_range(0, 9) < 7);
      tick();
      if (acc_last) begin
        sent++;
        in_a      = 16'($urandom);
        in_b      = 16'($urandom);
        in_sub    = 1'($urandom);
        in_signed = 1'($urandom);
      end
    end
    chk("rand_sent", 32'(sent), 32'd1000);
    in_valid = 1'b0;
    in_ready = 1'b1;
    for (int t = 0; t < 20; t++) tick();
    chk("rand_popped", 32'(popped - base), 32'd1000);
    chk("rand_queue_empty", 32'(q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_add_pipe

`default_nettype wire
